// File: rtl/monobit_window_ctrl.sv
// Monobit frequency-test window sequencer: clears the accumulator, gates
// cfg_len accepted bits into it, then judges |S| against the threshold.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   ena                global enable (0 freezes everything)
//   start, abort       window control
//   cfg_len            window length in bits (latched on start)
//   cfg_thresh         unsigned |S| pass threshold (latched on start)
//   bit_valid          upstream bit available this cycle
//   acc_sum            signed running sum (ones - zeros)
//   acc_clr, acc_en    accumulator clear / consume strobes
//   busy, done         window in progress / one-cycle result pulse
//   pass, fail, err    held result flags
//   bits_seen          bits accepted in current or last window
module monobit_window_ctrl #(
    parameter int CNT_W = 16,
    parameter int SUM_W = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] cfg_len,
    input  logic [SUM_W-2:0] cfg_thresh,
    input  logic             bit_valid,
    input  logic [SUM_W-1:0] acc_sum,
    output logic             acc_clr,
    output logic             acc_en,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             err,
    output logic [CNT_W-1:0] bits_seen
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_COLLECT,
        S_EVAL,
        S_REPORT
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] len_q;
    logic [SUM_W-2:0] thresh_q;
    logic             go;
    logic             last_bit;
    logic             in_window;
    logic [SUM_W-1:0] mag;
    logic             res_pass;

    assign go        = (state_q == S_IDLE) && start && !abort;
    assign last_bit  = (bits_seen == len_q - CNT_W'(1));
    assign in_window = (state_q == S_CLEAR) || (state_q == S_COLLECT) ||
                       (state_q == S_EVAL);

    // Two's-complement magnitude kept at full SUM_W width so the
    // most-negative sum maps to 2^(SUM_W-1) instead of wrapping.
    assign mag      = acc_sum[SUM_W-1] ? (~acc_sum + SUM_W'(1)) : acc_sum;
    assign res_pass = (mag <= {1'b0, thresh_q});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else if (ena) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d = (cfg_len == '0) ? S_REPORT : S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_d = abort ? S_IDLE : S_COLLECT;
            end
            S_COLLECT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (bit_valid && last_bit) begin
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                state_d = abort ? S_IDLE : S_REPORT;
            end
            S_REPORT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        acc_clr = ena && (state_q == S_CLEAR);
        acc_en  = ena && (state_q == S_COLLECT) && bit_valid && !abort;
        done    = ena && (state_q == S_REPORT);
        busy    = (state_q != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q     <= '0;
            thresh_q  <= '0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            err       <= 1'b0;
            bits_seen <= '0;
        end else if (ena) begin
            if (go) begin
                len_q     <= cfg_len;
                thresh_q  <= cfg_thresh;
                pass      <= 1'b0;
                fail      <= 1'b0;
                err       <= (cfg_len == '0);
                bits_seen <= '0;
            end
            if (acc_en) begin
                bits_seen <= bits_seen + CNT_W'(1);
            end
            if (state_q == S_EVAL && !abort) begin
                pass <= res_pass;
                fail <= !res_pass;
            end
            if (in_window && abort) begin
                pass <= 1'b0;
                fail <= 1'b0;
                err  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_monobit_window_ctrl.sv
// Testbench for monobit_window_ctrl: phase-level reference model checked
// every cycle, plus directed windows with hand-computed results.
module tb_monobit_window_ctrl;

    localparam int CNT_W = 16;
    localparam int SUM_W = 17;

    localparam int P_IDLE = 0;
    localparam int P_CLR  = 1;
    localparam int P_COL  = 2;
    localparam int P_EVAL = 3;
    localparam int P_REP  = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ena;
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] cfg_len;
    logic [SUM_W-2:0] cfg_thresh;
    logic             bit_valid;
    logic [SUM_W-1:0] acc_sum;
    logic             acc_clr;
    logic             acc_en;
    logic             busy;
    logic             done;
    logic             pass;
    logic             fail;
    logic             err;
    logic [CNT_W-1:0] bits_seen;

    int tests = 0;
    int fails = 0;

    monobit_window_ctrl #(.CNT_W(CNT_W), .SUM_W(SUM_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .start      (start),
        .abort      (abort),
        .cfg_len    (cfg_len),
        .cfg_thresh (cfg_thresh),
        .bit_valid  (bit_valid),
        .acc_sum    (acc_sum),
        .acc_clr    (acc_clr),
        .acc_en     (acc_en),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .fail       (fail),
        .err        (err),
        .bits_seen  (bits_seen)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
                     $time);
        end
    endtask

    // External accumulator emulation: data bits come from a pattern,
    // one bit per accept, LSB first.
    logic [31:0]      pat;
    int               pidx;
    int               s_acc;
    logic             force_en;
    logic [SUM_W-1:0] force_val;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_acc <= 0;
            pidx  <= 0;
        end else if (acc_clr) begin
            s_acc <= 0;
            pidx  <= 0;
        end else if (acc_en) begin
            s_acc <= s_acc + (pat[pidx] ? 1 : -1);
            pidx  <= pidx + 1;
        end
    end

    assign acc_sum = force_en ? force_val : SUM_W'(s_acc);

    // Reference model, phase by phase.
    int          ph;
    int          m_len;
    int          m_th;
    int          m_seen;
    logic        m_pass;
    logic        m_fail;
    logic        m_err;
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph     <= P_IDLE;
            m_len  <= 0;
            m_th   <= 0;
            m_seen <= 0;
            m_pass <= 1'b0;
            m_fail <= 1'b0;
            m_err  <= 1'b0;
        end else if (ena) begin
            if (ph == P_IDLE) begin
                if (start && !abort) begin
                    m_len  <= int'(cfg_len);
                    m_th   <= int'(cfg_thresh);
                    m_seen <= 0;
                    m_pass <= 1'b0;
                    m_fail <= 1'b0;
                    m_err  <= (cfg_len == 0);
                    ph     <= (cfg_len == 0) ? P_REP : P_CLR;
                end
            end else if (ph == P_REP) begin
                ph <= P_IDLE;
            end else if (abort) begin
                ph     <= P_IDLE;
                m_pass <= 1'b0;
                m_fail <= 1'b0;
                m_err  <= 1'b0;
            end else if (ph == P_CLR) begin
                ph <= P_COL;
            end else if (ph == P_COL) begin
                if (bit_valid) begin
                    m_seen <= m_seen + 1;
                    if (m_seen + 1 == m_len) ph <= P_EVAL;
                end
            end else begin
                int sv;
                int mg;
                sv = int'($signed(acc_sum));
                mg = (sv < 0) ? -sv : sv;
                m_pass <= (mg <= m_th);
                m_fail <= !(mg <= m_th);
                ph     <= P_REP;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        logic [23:0] act;
        logic [23:0] exp;
        act = {acc_clr, acc_en, busy, done, pass, fail, err, bits_seen};
        exp = {ena && ph == P_CLR,
               ena && ph == P_COL && bit_valid && !abort,
               ph != P_IDLE,
               ena && ph == P_REP,
               m_pass, m_fail, m_err, CNT_W'(m_seen)};
        chk("cycle", 64'(act), 64'(exp));
    end

    // Event counters for directed checks.
    int n_en;
    int n_clr;
    int n_done;
    int n_frz;
    int last_en;
    int first_clr;
    int done_cyc;

    always @(negedge clk) begin
        if (rst_n) begin
            if (acc_en) begin
                n_en++;
                last_en = cyc;
            end
            if (acc_clr) begin
                if (n_clr == 0) first_clr = cyc;
                n_clr++;
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (!ena && (acc_en || acc_clr || done)) n_frz++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_counts();
        n_en = 0; n_clr = 0; n_done = 0; n_frz = 0;
        last_en = -1; first_clr = -1; done_cyc = -1;
    endtask

    task automatic go(input int len, input int th, output int scyc);
        cfg_len    = CNT_W'(len);
        cfg_thresh = (SUM_W-1)'(th);
        start      = 1'b1;
        scyc       = cyc;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (n_done == 0 && k < budget) begin
            tick();
            k++;
        end
        chk("done_seen", 64'(n_done != 0), 64'd1);
    endtask

    int sc;

    initial begin
        rst_n = 1'b0; ena = 1'b1; start = 1'b0; abort = 1'b0;
        cfg_len = '0; cfg_thresh = '0; bit_valid = 1'b0;
        pat = '0; force_en = 1'b0; force_val = '0;
        clr_counts();
        tick(); tick();
        chk("reset_outs", 64'({acc_clr, acc_en, busy, done, pass, fail, err,
            bits_seen}), 64'd0);
        rst_n = 1'b1;
        tick();

        // Async reset in the middle of a window.
        pat = 32'hFFFF_FFFF;
        bit_valid = 1'b1;
        go(8, 2, sc);
        tick(); tick(); tick();
        chk("pre_rst_busy", 64'(busy), 64'd1);
        chk("pre_rst_seen", 64'(bits_seen), 64'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst", 64'({acc_clr, acc_en, busy, done, pass, fail, err,
            bits_seen}), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // len 8, sum +2, thresh 2 -> pass.
        clr_counts();
        pat = 32'h0000_001F;
        go(8, 2, sc);
        wait_done(40);
        chk("w8_acc_en", 64'(n_en), 64'd8);
        chk("w8_acc_clr", 64'(n_clr), 64'd1);
        chk("w8_clr_lat", 64'(first_clr - sc), 64'd1);
        chk("w8_done_lat", 64'(done_cyc - last_en), 64'd2);
        chk("w8_pf", 64'({pass, fail}), 64'b10);
        chk("w8_seen", 64'(bits_seen), 64'd8);
        tick(); tick();
        chk("w8_one_done", 64'(n_done), 64'd1);

        // sum +4 -> fail.
        clr_counts();
        pat = 32'h0000_003F;
        go(8, 2, sc);
        wait_done(40);
        chk("p4_pf", 64'({pass, fail, err}), 64'b010);

        // sum -2 -> pass.
        clr_counts();
        pat = 32'h0000_0007;
        go(8, 2, sc);
        wait_done(40);
        chk("m2_pf", 64'({pass, fail}), 64'b10);

        // Most-negative sum against the largest threshold -> fail.
        clr_counts();
        force_en  = 1'b1;
        force_val = 17'h10000;
        go(8, 16'hFFFF, sc);
        wait_done(40);
        chk("minneg_pf", 64'({pass, fail}), 64'b01);
        force_en = 1'b0;
        tick();

        // len 4 with toggling bit_valid and a 3-cycle freeze.
        clr_counts();
        pat = 32'hFFFF_FFFF;
        bit_valid = 1'b0;
        go(4, 4, sc);
        for (int i = 0; i < 40; i++) begin
            bit_valid = (i % 2 == 0);
            ena       = !(i >= 3 && i < 6);
            tick();
            if (n_done != 0) break;
        end
        ena = 1'b1;
        chk("ena_done", 64'(n_done), 64'd1);
        chk("ena_acc_en", 64'(n_en), 64'd4);
        chk("ena_frozen", 64'(n_frz), 64'd0);
        chk("ena_seen", 64'(bits_seen), 64'd4);
        chk("ena_pass", 64'(pass), 64'd1);

        // Abort after 3 accepts; start while busy is ignored.
        clr_counts();
        bit_valid = 1'b1;
        go(16, 2, sc);
        for (int k = 0; k < 20 && n_en < 1; k++) tick();
        cfg_len = 16'd2;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        for (int k = 0; k < 20 && n_en < 3; k++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_seen", 64'(bits_seen), 64'd3);
        chk("abort_pf", 64'({pass, fail, err}), 64'b000);
        tick(); tick(); tick();
        chk("abort_nodone", 64'(n_done), 64'd0);
        clr_counts();
        go(3, 5, sc);
        wait_done(40);
        chk("restart_en", 64'(n_en), 64'd3);
        chk("restart_pass", 64'({pass, fail}), 64'b10);

        // Zero-length window reports err straight away.
        clr_counts();
        go(0, 2, sc);
        wait_done(10);
        chk("zero_lat", 64'(done_cyc - sc), 64'd1);
        chk("zero_noacc", 64'(n_en + n_clr), 64'd0);
        chk("zero_flags", 64'({pass, fail, err}), 64'b001);

        // start with abort in IDLE: abort wins.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("sa_idle", 64'({busy, err}), 64'b01);
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
